nonce_target_scan: RTL
======================

Name: nonce_target_scan

Overview:
- Downstream stage of the bitcoin nonce-hashing block.
- After the hasher writes one 32-bit H0 word per nonce to memory, this block reads those words back.
- It compares each word against a difficulty target and tracks the minimum hash and its nonce index.
- It writes a two-word result record to memory and exposes the winner on ports for the top-level controller.

Parameters:
- NUM_NONCES, 16, number of consecutive hash words to scan; legal range 1..65535.
- IDX_W, 16, width of nonce index fields; must satisfy 2^IDX_W >= NUM_NONCES.

Ports:
- clk  input  1  sole clock; also drives mem_clk.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- hash_addr  input  16  base address of the NUM_NONCES H0 words; sampled at start.
- result_addr  input  16  base address of the result record; sampled at start.
- target  input  32  difficulty target; sampled at start.
- done  output  1  high while in IDLE.
- mem_clk  output  1  equal to clk.
- mem_we  output  1  memory write enable.
- mem_addr  output  16  memory address.
- mem_write_data  output  32  memory write data.
- mem_read_data  input  32  read data; valid the cycle after its address is presented.
- found  output  1  at least one hash is strictly below target; held until the next start.
- best_nonce  output  IDX_W  index of the minimum hash; held until the next start.
- best_hash  output  32  minimum hash value; held until the next start.

Behaviour:
- Reset values:
  - state=IDLE, done=1, mem_we=0.
  - mem_addr=0, mem_write_data=0.
  - found=0, best_nonce=0, best_hash=32'hFFFFFFFF.
- State IDLE:
  - On start=1: latch hash_addr, result_addr and target.
  - Clear rd_cnt and cmp_cnt; set best_hash=FFFFFFFF, best_nonce=0, found=0.
  - Go to READ.
- State READ:
  - Present mem_addr = hash_addr + rd_cnt (16-bit, wraps modulo 2^16), with mem_we=0.
  - Increment rd_cnt each cycle.
  - After rd_cnt reaches NUM_NONCES-1, go to DRAIN.
- Comparison: one cycle after each address is presented, the comparator samples mem_read_data as hash word cmp_cnt.
  - If word < best_hash (unsigned, strict): update best_hash and best_nonce=cmp_cnt. Ties keep the lower index.
  - If word < target (strict): set found=1.
  - cmp_cnt increments for every compared word.
- State DRAIN: one cycle; compares the final word. Go to WR0.
- State WR0:
  - mem_we=1, mem_addr=result_addr.
  - mem_write_data = {found, (15-(IDX_W-16)) zero bits, best_nonce}. With IDX_W=16 the layout is found in bit 31, bits 30:16 zero, best_nonce in bits 15:0.
  - Go to WR1.
- State WR1:
  - mem_we=1, mem_addr=result_addr+1, mem_write_data=best_hash.
  - Go to IDLE; mem_we returns to 0.
- Latency: with start sampled on edge 0, done rises after edge NUM_NONCES+4. That is 20 cycles for the default.
- start outside IDLE is ignored; no queuing.
- Reset asserted mid-operation: immediately return to IDLE with reset values. Any partially written record is left as-is.
- Input changes after start do not affect the scan in progress.

Optional Feature:
- Macro: NONCE_TARGET_SCAN_HITCOUNT_EN.
- Defined:
  - Add a counter of words strictly below target, saturating at 2^IDX_W-1.
  - Add state WR2 after WR1, writing {16'b0, hit_count} to result_addr+2.
  - Latency becomes NUM_NONCES+5.
  - Add output port hit_count (IDX_W bits), reset to 0 and cleared on start.
- Undefined: two-word record only; no hit_count port.

Decomposition:
- Shared package nonce_scan_pkg:
  - state enum (IDLE, READ, DRAIN, WR0, WR1, WR2).
  - RESULT_WORDS constant.
  - result-word bit positions (FOUND_BIT=31, IDX_LSB=0).
- Natural sub-module: scan_min_tracker.
  - Inputs: clear, valid, word, target.
  - Outputs: best_hash, best_nonce, found, optional hit_count.
  - The FSM and memory sequencing stay in the top module.

Test Plan:
- Words 0x50,0x40,0x30,…,0x00 (descending by 0x10 per index, with an extra 0x00 at index 6), remaining words 0xFFFFFFFF, target=0x35 -> best_nonce=5, best_hash=0, found=1; memory word0=0x80000005, word1=0x00000000; done high 20 cycles after start.
- All words 0x90000000+i, target=0x10000000 -> found=0, best_nonce=0, best_hash=0x90000000, word0=0x00000000.
- Words at index 3 and 9 both equal 0x00000007 (global minimum) -> best_nonce=3 (lower index wins).
- hash_addr=0xFFF8, NUM_NONCES=16 -> reads addresses FFF8..FFFF, then 0000..0007 in order; result is correct.
- start pulsed again during READ -> ignored; exactly 2 writes occur; done timing unchanged. Then reset_n pulsed low in READ -> done=1 and mem_we=0 at once; no result writes.
- With NONCE_TARGET_SCAN_HITCOUNT_EN and 4 words below target -> word2=0x00000004, hit_count=4, latency 21 cycles.

Source files
------------

// File: rtl/nonce_scan_pkg.sv
// Shared types and result-record layout for the nonce target scanner.
// RESULT_WORDS grows to 3 when NONCE_TARGET_SCAN_HITCOUNT_EN is defined.
package nonce_scan_pkg;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WR0, WR1, WR2} state_t;

`ifdef NONCE_TARGET_SCAN_HITCOUNT_EN
  localparam int RESULT_WORDS = 3;
`else
  localparam int RESULT_WORDS = 2;
`endif

  localparam int FOUND_BIT = 31;
  localparam int IDX_LSB   = 0;

endpackage

// File: rtl/scan_min_tracker.sv
// Running minimum / below-target tracker over a stream of 32-bit hash words.
// NONCE_TARGET_SCAN_HITCOUNT_EN adds a saturating count of below-target words.
module scan_min_tracker #(
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             valid,
  input  logic [31:0]      word,
  input  logic [31:0]      target,
  output logic [31:0]      best_hash,
  output logic [IDX_W-1:0] best_nonce,
  output logic             found
`ifdef NONCE_TARGET_SCAN_HITCOUNT_EN
  ,
  output logic [IDX_W-1:0] hit_count
`endif
);

  logic [IDX_W-1:0] cmp_cnt;

  // strict compare keeps the earliest index on ties
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      best_hash  <= 32'hFFFF_FFFF;
      best_nonce <= '0;
      found      <= 1'b0;
      cmp_cnt    <= '0;
    end else if (clear) begin
      best_hash  <= 32'hFFFF_FFFF;
      best_nonce <= '0;
      found      <= 1'b0;
      cmp_cnt    <= '0;
    end else if (valid) begin
      if (word < best_hash) begin
        best_hash  <= word;
        best_nonce <= cmp_cnt;
      end
      if (word < target) begin
        found <= 1'b1;
      end
      cmp_cnt <= cmp_cnt + 1'b1;
    end
  end

`ifdef NONCE_TARGET_SCAN_HITCOUNT_EN
  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count <= '0;
    end else if (clear) begin
      hit_count <= '0;
    end else if (valid && (word < target)) begin
      hit_count <= sat_inc(hit_count);
    end
  end
`endif

endmodule

// File: rtl/nonce_target_scan.sv
// Reads back NUM_NONCES hash words, tracks min/below-target, writes a result record.
// Optional NONCE_TARGET_SCAN_HITCOUNT_EN appends a hit-count word and port.
module nonce_target_scan
  import nonce_scan_pkg::*;
#(
  parameter int NUM_NONCES = 16,
  parameter int IDX_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      hash_addr,
  input  logic [15:0]      result_addr,
  input  logic [31:0]      target,
  output logic             done,
  output logic             mem_clk,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data,
  output logic             found,
  output logic [IDX_W-1:0] best_nonce,
  output logic [31:0]      best_hash
`ifdef NONCE_TARGET_SCAN_HITCOUNT_EN
  ,
  output logic [IDX_W-1:0] hit_count
`endif
);

  localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(NUM_NONCES - 1);

  state_t           state, state_next;
  logic [15:0]      hash_addr_q, result_addr_q;
  logic [31:0]      target_q;
  logic [IDX_W-1:0] rd_cnt;
  logic             clear;
  logic             vld_p0, vld_p1;
  logic             done_q;
  logic [31:0]      status_word;

  assign mem_clk = clk;
  assign done    = done_q;
  assign vld_p0  = (state == READ);

  // operands are only meaningful after a start, so they carry no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      hash_addr_q   <= hash_addr;
      result_addr_q <= result_addr;
      target_q      <= target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rd_cnt <= '0;
      vld_p1 <= 1'b0;
      done_q <= 1'b1;
    end else begin
      state  <= state_next;
      vld_p1 <= vld_p0;
      done_q <= (state == IDLE);
      if (clear) begin
        rd_cnt <= '0;
      end else if (state == READ) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state;
    clear          = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    status_word    = '0;
    status_word[IDX_LSB +: IDX_W] = best_nonce;
    status_word[FOUND_BIT]        = found;
    case (state)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        mem_addr = hash_addr_q + 16'(rd_cnt);
        if (rd_cnt == RD_LAST) state_next = DRAIN;
      end
      DRAIN: state_next = WR0;
      WR0: begin
        mem_we         = 1'b1;
        mem_addr       = result_addr_q;
        mem_write_data = status_word;
        state_next     = WR1;
      end
      WR1: begin
        mem_we         = 1'b1;
        mem_addr       = result_addr_q + 16'd1;
        mem_write_data = best_hash;
        state_next     = (RESULT_WORDS > 2) ? WR2 : IDLE;
      end
      WR2: begin
`ifdef NONCE_TARGET_SCAN_HITCOUNT_EN
        mem_we         = 1'b1;
        mem_addr       = result_addr_q + 16'd2;
        mem_write_data = 32'(hit_count);
`endif
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // read data returns one cycle after its address: compare stage is p1
  scan_min_tracker #(.IDX_W(IDX_W)) u_tracker (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .valid      (vld_p1),
    .word       (mem_read_data),
    .target     (target_q),
    .best_hash  (best_hash),
    .best_nonce (best_nonce),
    .found      (found)
`ifdef NONCE_TARGET_SCAN_HITCOUNT_EN
    ,
    .hit_count  (hit_count)
`endif
  );

endmodule
